// File: rtl/mmio_hs_pkg.sv
// Shared types and helpers for the handshaking MMIO slot controller.
package mmio_hs_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    // Read data returned when an ack slot times out.
    localparam int RD_ERR_DATA = 0;

    function automatic int unsigned slot_of(input logic [63:0] addr, input int reg_aw, input int sb);
        logic [63:0] t;
        t = (addr >> reg_aw) & ((64'd1 << sb) - 64'd1);
        return 32'(t);
    endfunction

endpackage

// File: rtl/mmio_wait_timer.sv
// Saturating wait-cycle counter; flags expiry on the last allowed wait cycle without ack.
module mmio_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic ack,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && count != CW'(TIMEOUT))
            count <= count + 1'b1;
    end

    assign expired = en && !ack && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mmio_hs_slot_ctrl.sv
// MMIO slot decoder with per-slot ack handshake, timeout error and held read response.
module mmio_hs_slot_ctrl
    import mmio_hs_pkg::*;
#(
    parameter int                N_SLOT        = 64,
    parameter int                REG_AW        = 5,
    parameter int                ADDR_W        = 21,
    parameter int                DW            = 32,
    parameter logic [N_SLOT-1:0] SLOT_EN_MASK  = '1,
    parameter logic [N_SLOT-1:0] SLOT_ACK_MASK = '0,
    parameter int                TIMEOUT       = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mmio_cs,
    input  logic                          mmio_wr,
    input  logic                          mmio_rd,
    input  logic [ADDR_W-1:0]             mmio_addr,
    input  logic [DW-1:0]                 mmio_wr_data,
    output logic [DW-1:0]                 mmio_rd_data,
    output logic                          mmio_ready,
    output logic                          mmio_err,
    output logic                          mmio_busy,
    output logic [N_SLOT-1:0]             slot_cs_array,
    output logic [N_SLOT-1:0]             slot_mem_rd_array,
    output logic [N_SLOT-1:0]             slot_mem_wr_array,
    output logic [N_SLOT-1:0][REG_AW-1:0] slot_reg_addr_array,
    output logic [N_SLOT-1:0][DW-1:0]     slot_wr_data_array,
    input  logic [N_SLOT-1:0][DW-1:0]     slot_rd_data_array,
    input  logic [N_SLOT-1:0]             slot_ack_array
);
    localparam int SB = $clog2(N_SLOT);

    state_t            state_q, state_d;
    logic [SB-1:0]     slot_q;
    logic [REG_AW-1:0] reg_q;
    op_t               op_q;
    logic [DW-1:0]     wdata_q;
    logic              err_q, err_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;

    logic [SB-1:0]     req_slot;
    logic              req_go, req_bad, capture;
    logic              active, done, expired;

    assign req_slot = SB'(slot_of(64'(mmio_addr), REG_AW, SB));
    assign req_go   = mmio_cs && (mmio_rd ^ mmio_wr) && SLOT_EN_MASK[req_slot];
    assign req_bad  = mmio_cs && ((mmio_rd && mmio_wr) ||
                                  ((mmio_rd ^ mmio_wr) && !SLOT_EN_MASK[req_slot]));

    assign active = (state_q == ISSUE) || (state_q == WAIT);
    // Slots outside the ack mask complete in the same cycle they are issued.
    assign done   = active && (!SLOT_ACK_MASK[slot_q] || slot_ack_array[slot_q]);

    mmio_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!active),
        .en      (active),
        .ack     (done),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        rd_data_d = rd_data_q;
        capture   = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (req_go) begin
                    state_d = ISSUE;
                    capture = 1'b1;
                end else if (req_bad) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            ISSUE, WAIT: begin
                state_d = WAIT;
                if (done) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (op_q == OP_RD)
                        rd_data_d = slot_rd_data_array[slot_q];
                end else if (expired) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    if (op_q == OP_RD)
                        rd_data_d = DW'(RD_ERR_DATA);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            slot_q    <= '0;
            reg_q     <= '0;
            op_q      <= OP_RD;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            if (capture) begin
                slot_q  <= req_slot;
                reg_q   <= mmio_addr[REG_AW-1:0];
                op_q    <= mmio_wr ? OP_WR : OP_RD;
                wdata_q <= mmio_wr_data;
            end
        end
    end

    assign mmio_rd_data = rd_data_q;
    assign mmio_ready   = (state_q == RESP);
    assign mmio_err     = (state_q == RESP) && err_q;
    assign mmio_busy    = (state_q != IDLE);

    for (genvar i = 0; i < N_SLOT; i++) begin : g_slot
        logic sel;
        assign sel                    = (slot_q == SB'(i));
        assign slot_cs_array[i]       = active && sel;
        assign slot_mem_rd_array[i]   = (state_q == ISSUE) && (op_q == OP_RD) && sel;
        assign slot_mem_wr_array[i]   = (state_q == ISSUE) && (op_q == OP_WR) && sel;
        assign slot_reg_addr_array[i] = reg_q;
        assign slot_wr_data_array[i]  = wdata_q;
    end

endmodule

// File: tb/tb_mmio_hs_slot_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor checks each ready pulse.
module tb_mmio_hs_slot_ctrl;
    localparam int N_SLOT = 8, REG_AW = 5, ADDR_W = 21, DW = 32, TIMEOUT = 15;

    logic clk, reset, mmio_cs, mmio_wr, mmio_rd;
    logic [ADDR_W-1:0] mmio_addr;
    logic [DW-1:0] mmio_wr_data, mmio_rd_data;
    logic mmio_ready, mmio_err, mmio_busy;
    logic [N_SLOT-1:0] slot_cs_array, slot_mem_rd_array, slot_mem_wr_array, slot_ack_array;
    logic [N_SLOT-1:0][REG_AW-1:0] slot_reg_addr_array;
    logic [N_SLOT-1:0][DW-1:0] slot_wr_data_array, slot_rd_data_array;

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
        int            tag;
    } exp_t;

    exp_t sb_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    mmio_hs_slot_ctrl #(
        .N_SLOT(N_SLOT), .REG_AW(REG_AW), .ADDR_W(ADDR_W), .DW(DW),
        .SLOT_EN_MASK(8'b0111_1111), .SLOT_ACK_MASK(8'b0010_0000), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
        .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(mmio_rd_data),
        .mmio_ready(mmio_ready), .mmio_err(mmio_err), .mmio_busy(mmio_busy),
        .slot_cs_array(slot_cs_array), .slot_mem_rd_array(slot_mem_rd_array),
        .slot_mem_wr_array(slot_mem_wr_array), .slot_reg_addr_array(slot_reg_addr_array),
        .slot_wr_data_array(slot_wr_data_array), .slot_rd_data_array(slot_rd_data_array),
        .slot_ack_array(slot_ack_array)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; pushes the expected response when one is due.
    task automatic req(input logic rd, input logic wr, input int slot, input int rg,
                       input logic [DW-1:0] wd, input int tag, input logic eerr,
                       input logic [DW-1:0] edata, input int lat, input bit want);
        mmio_cs      = 1'b1;
        mmio_rd      = rd;
        mmio_wr      = wr;
        mmio_addr    = ADDR_W'(slot * (1 << REG_AW) + rg);
        mmio_wr_data = wd;
        tick();
        mmio_cs = 1'b0;
        mmio_rd = 1'b0;
        mmio_wr = 1'b0;
        if (want) sb_q.push_back('{eerr, edata, cyc + lat - 1, tag});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && mmio_ready === 1'b1) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ready: got ready err=%0b at cycle %0d, expected none", mmio_err, cyc);
            end else begin
                e = sb_q.pop_front();
                if (mmio_err !== e.err || mmio_rd_data !== e.data || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL resp_%0d: got err=%0b data=%h cyc=%0d expected err=%0b data=%h cyc=%0d",
                             e.tag, mmio_err, mmio_rd_data, cyc, e.err, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        reset = 1'b0; mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
        mmio_addr = '0; mmio_wr_data = '0;
        slot_ack_array = '0; slot_rd_data_array = '0;
        slot_rd_data_array[1] = 32'h0000_BEEF;
        slot_rd_data_array[3] = 32'h1234_5678;
        slot_rd_data_array[4] = 32'h4444_0004;
        slot_rd_data_array[5] = 32'h0000_CAFE;
        #12;
        check("reset_ctl", {mmio_ready, mmio_err, mmio_busy, slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, '0);
        check("reset_rd_data", mmio_rd_data, '0);
        #10 reset = 1'b1;
        tick();

        // zero-wait read slot 3 reg 2, then a write to slot 2 accepted on the RESP edge
        req(1'b1, 1'b0, 3, 2, '0, 1, 1'b0, 32'h1234_5678, 2, 1'b1);
        @(negedge clk);
        check("rd3_cs", slot_cs_array, 8'h08);
        check("rd3_rd", slot_mem_rd_array, 8'h08);
        check("rd3_wr", slot_mem_wr_array, 8'h00);
        check("rd3_reg", slot_reg_addr_array[3], 5'd2);
        tick();
        check("rd3_drop", {slot_cs_array, slot_mem_rd_array}, '0);
        req(1'b0, 1'b1, 2, 0, 32'hA5, 2, 1'b0, 32'h1234_5678, 2, 1'b1);
        @(negedge clk);
        check("wr2_wr", slot_mem_wr_array, 8'h04);
        check("wr2_cs_rd", {slot_cs_array, slot_mem_rd_array}, {8'h04, 8'h00});
        check("wr2_reg", slot_reg_addr_array[2], 5'd0);
        check("wr2_data", {slot_wr_data_array[2], slot_wr_data_array[7]}, {32'hA5, 32'hA5});
        tick(); tick();

        // ack slot 5: stray ack on slot 6 at T+3, real ack at T+4
        req(1'b1, 1'b0, 5, 1, '0, 3, 1'b0, 32'h0000_CAFE, 5, 1'b1);
        @(negedge clk);
        check("ack5_issue", {slot_cs_array, slot_mem_rd_array}, {8'h20, 8'h20});
        tick();
        @(negedge clk);
        check("ack5_wait", {mmio_busy, slot_cs_array, slot_mem_rd_array}, {1'b1, 8'h20, 8'h00});
        tick();
        slot_ack_array[6] = 1'b1;
        @(negedge clk);
        check("ack5_stray", slot_cs_array, 8'h20);
        tick();
        slot_ack_array = '0;
        slot_ack_array[5] = 1'b1;
        @(negedge clk);
        check("ack5_hold", slot_cs_array, 8'h20);
        tick();
        slot_ack_array = '0;
        check("ack5_resp_cs", slot_cs_array, 8'h00);
        tick(); tick();

        // timeout on slot 5; a write offered at T+8 must be ignored
        req(1'b1, 1'b0, 5, 3, '0, 4, 1'b1, 32'h0, TIMEOUT + 1, 1'b1);
        repeat (7) tick();
        mmio_cs = 1'b1; mmio_wr = 1'b1;
        mmio_addr = ADDR_W'(2 * (1 << REG_AW)); mmio_wr_data = 32'h77;
        @(negedge clk);
        check("to_busy", {mmio_busy, slot_mem_wr_array}, {1'b1, 8'h00});
        tick();
        mmio_cs = 1'b0; mmio_wr = 1'b0;
        @(negedge clk);
        check("to_cs_held", {slot_cs_array, slot_mem_wr_array}, {8'h20, 8'h00});
        repeat (10) tick();

        // rejects: disabled slot 7, then rd=wr=1 after loading BEEF
        req(1'b1, 1'b0, 7, 0, '0, 5, 1'b1, 32'h0, 1, 1'b1);
        @(negedge clk);
        check("rej7_strobes", {slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, '0);
        tick(); tick();
        req(1'b1, 1'b0, 1, 4, '0, 6, 1'b0, 32'h0000_BEEF, 2, 1'b1);
        tick(); tick();
        req(1'b1, 1'b1, 1, 4, '0, 7, 1'b1, 32'h0000_BEEF, 1, 1'b1);
        @(negedge clk);
        check("rdwr_strobes", {slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, '0);
        tick(); tick();
        mmio_cs = 1'b1; mmio_addr = ADDR_W'(3 * (1 << REG_AW));
        tick();
        mmio_cs = 1'b0;
        @(negedge clk);
        check("cs_only_ignored", {mmio_busy, slot_cs_array}, '0);
        tick();

        // asynchronous reset during WAIT aborts the access
        req(1'b1, 1'b0, 5, 9, 32'h55, 8, 1'b0, '0, 1, 1'b0);
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        check("rst_ctl", {mmio_ready, mmio_err, mmio_busy, slot_cs_array, slot_mem_rd_array, slot_mem_wr_array}, '0);
        check("rst_rd_data", mmio_rd_data, '0);
        check("rst_arrays", {slot_reg_addr_array[5], slot_wr_data_array[5]}, '0);
        @(negedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        req(1'b1, 1'b0, 4, 1, '0, 9, 1'b0, 32'h4444_0004, 2, 1'b1);
        @(negedge clk);
        check("post_rst_rd4", {slot_cs_array, slot_mem_rd_array}, {8'h10, 8'h10});
        repeat (3) tick();

        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending responses expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
